// File: rtl/change_dispenser.sv
// Change-return back end: greedily converts a change amount (5-cent units) into
// timed quarter/dime/nickel eject pulses against a per-denomination inventory.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int INV_W        = 6,
    parameter int INIT_Q       = 20,
    parameter int INIT_D       = 20,
    parameter int INIT_N       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [7:0]       req_amount,
    output logic             req_ready,
    input  logic             refill_valid,
    input  logic [1:0]       refill_coin,
    output logic             eject_q,
    output logic             eject_d,
    output logic             eject_n,
    output logic             done,
    output logic             short,
    output logic [7:0]       remaining,
    output logic [INV_W-1:0] inv_q,
    output logic [INV_W-1:0] inv_d,
    output logic [INV_W-1:0] inv_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [INV_W-1:0] INV_MAX   = {INV_W{1'b1}};
    localparam logic [15:0]      PULSE_END = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0]      GAP_END   = 16'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       ej_q, ej_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [INV_W-1:0] qinv_q, dinv_q, ninv_q;
    logic             dec_q, dec_d, dec_n;
    logic             inc_q, inc_d, inc_n;

    // A simultaneous refill and dispense on one counter cancel out.
    function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                   input logic inc, input logic dec);
        logic [INV_W-1:0] nxt;
        nxt = cur;
        if (inc && !dec && cur != INV_MAX) nxt = cur + INV_W'(1);
        else if (dec && !inc)              nxt = cur - INV_W'(1);
        return nxt;
    endfunction

    assign inc_q = refill_valid && (refill_coin == 2'b10);
    assign inc_d = refill_valid && (refill_coin == 2'b01);
    assign inc_n = refill_valid && (refill_coin == 2'b00);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        ej_d        = ej_q;
        done_d      = 1'b0;
        short_d     = short_q;
        remaining_d = remaining_q;
        dec_q       = 1'b0;
        dec_d       = 1'b0;
        dec_n       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rem_d       = req_amount;
                    short_d     = 1'b0;
                    remaining_d = 8'd0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = 16'd0;
                if (rem_q >= 8'd5 && qinv_q != '0) begin
                    rem_d   = rem_q - 8'd5;
                    dec_q   = 1'b1;
                    ej_d    = 3'b100;
                    state_d = S_PULSE;
                end else if (rem_q >= 8'd2 && dinv_q != '0) begin
                    rem_d   = rem_q - 8'd2;
                    dec_d   = 1'b1;
                    ej_d    = 3'b010;
                    state_d = S_PULSE;
                end else if (rem_q >= 8'd1 && ninv_q != '0) begin
                    rem_d   = rem_q - 8'd1;
                    dec_n   = 1'b1;
                    ej_d    = 3'b001;
                    state_d = S_PULSE;
                end else begin
                    done_d      = 1'b1;
                    short_d     = (rem_q != 8'd0);
                    remaining_d = rem_q;
                    state_d     = S_DONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == PULSE_END) begin
                    cnt_d   = 16'd0;
                    ej_d    = 3'b000;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = 16'd0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= 8'd0;
            cnt_q       <= 16'd0;
            ej_q        <= 3'b000;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= 8'd0;
            qinv_q      <= INV_W'(INIT_Q);
            dinv_q      <= INV_W'(INIT_D);
            ninv_q      <= INV_W'(INIT_N);
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            ej_q        <= ej_d;
            done_q      <= done_d;
            short_q     <= short_d;
            remaining_q <= remaining_d;
            qinv_q      <= inv_next(qinv_q, inc_q, dec_q);
            dinv_q      <= inv_next(dinv_q, inc_d, dec_d);
            ninv_q      <= inv_next(ninv_q, inc_n, dec_n);
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign eject_q   = ej_q[2];
    assign eject_d   = ej_q[1];
    assign eject_n   = ej_q[0];
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = remaining_q;
    assign inv_q     = qinv_q;
    assign inv_d     = dinv_q;
    assign inv_n     = ninv_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a greedy reference model pushes expected
// request outcomes to a scoreboard that is popped when each request completes.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 4;
    localparam int T = 1 + P + G;

    typedef struct {
        int         dcyc;
        logic       sh;
        logic [7:0] rem;
        int         iq;
        int         id;
        int         in_;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] amt;
    logic       rv [3];
    logic       ref_v;
    logic [1:0] ref_c;

    logic       rdy [3];
    logic       ejq [3];
    logic       ejd [3];
    logic       ejn [3];
    logic       dn  [3];
    logic       sh  [3];
    logic [7:0] rm  [3];
    logic [5:0] iq  [3];
    logic [5:0] id  [3];
    logic [5:0] inn [3];

    int         sel;
    logic       o_rdy, o_done, o_sh;
    logic [2:0] o_ej;
    logic [7:0] o_rm;
    logic [5:0] o_iq, o_id, o_in;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   minv [3][3];  // [dut][0=nickel,1=dime,2=quarter]
    exp_t sb [$];

    always #5 clk = ~clk;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .INV_W(6),
                       .INIT_Q(20), .INIT_D(20), .INIT_N(20)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_amount(amt), .req_ready(rdy[0]),
        .refill_valid(ref_v), .refill_coin(ref_c),
        .eject_q(ejq[0]), .eject_d(ejd[0]), .eject_n(ejn[0]),
        .done(dn[0]), .short(sh[0]), .remaining(rm[0]),
        .inv_q(iq[0]), .inv_d(id[0]), .inv_n(inn[0]));

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .INV_W(6),
                       .INIT_Q(0), .INIT_D(0), .INIT_N(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_amount(amt), .req_ready(rdy[1]),
        .refill_valid(1'b0), .refill_coin(2'b00),
        .eject_q(ejq[1]), .eject_d(ejd[1]), .eject_n(ejn[1]),
        .done(dn[1]), .short(sh[1]), .remaining(rm[1]),
        .inv_q(iq[1]), .inv_d(id[1]), .inv_n(inn[1]));

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .INV_W(6),
                       .INIT_Q(20), .INIT_D(20), .INIT_N(0)) dut_c (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_amount(amt), .req_ready(rdy[2]),
        .refill_valid(1'b0), .refill_coin(2'b00),
        .eject_q(ejq[2]), .eject_d(ejd[2]), .eject_n(ejn[2]),
        .done(dn[2]), .short(sh[2]), .remaining(rm[2]),
        .inv_q(iq[2]), .inv_d(id[2]), .inv_n(inn[2]));

    always_comb begin
        o_rdy  = rdy[sel];
        o_done = dn[sel];
        o_sh   = sh[sel];
        o_ej   = {ejq[sel], ejd[sel], ejn[sel]};
        o_rm   = rm[sel];
        o_iq   = iq[sel];
        o_id   = id[sel];
        o_in   = inn[sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_invs(input string tag, input int s);
        check({tag, " inv_q"}, 32'(o_iq), 32'(minv[s][2]));
        check({tag, " inv_d"}, 32'(o_id), 32'(minv[s][1]));
        check({tag, " inv_n"}, 32'(o_in), 32'(minv[s][0]));
    endtask

    // Model the request, push the expectation, then drive it and compare cycle by cycle.
    task automatic run_req(input string tag, input int s, input int amount, input bit refill_at_sel);
        int   coins [$];
        int   rem;
        int   c;
        int   k;
        int   off;
        exp_t e;
        exp_t got;
        bit   popped;
        logic [2:0] ej_e;

        rem = amount;
        for (int i = 0; i < 64; i++) begin
            c = -1;
            if (rem >= 5 && minv[s][2] > 0)      begin c = 2; rem -= 5; end
            else if (rem >= 2 && minv[s][1] > 0) begin c = 1; rem -= 2; end
            else if (rem >= 1 && minv[s][0] > 0) begin c = 0; rem -= 1; end
            if (c >= 0) minv[s][c]--;
            if (i == 0 && refill_at_sel) minv[s][2] = (minv[s][2] + 1 > 63) ? 63 : minv[s][2] + 1;
            if (c < 0) break;
            coins.push_back(c);
        end
        e.dcyc = 2 + coins.size() * T;
        e.sh   = (rem != 0);
        e.rem  = 8'(rem);
        e.iq   = minv[s][2];
        e.id   = minv[s][1];
        e.in_  = minv[s][0];
        sb.push_back(e);

        sel = s;
        @(negedge clk);
        amt   = 8'(amount);
        rv[s] = 1'b1;
        ref_c = 2'b10;
        @(posedge clk);
        #1 rv[s] = 1'b0;
        popped = 1'b0;
        for (int cyc = 1; cyc <= e.dcyc + 1; cyc++) begin
            @(negedge clk);
            ej_e = 3'b000;
            if (cyc >= 2) begin
                k   = (cyc - 2) / T;
                off = (cyc - 2) % T;
                if (k < coins.size() && off < P) ej_e[coins[k]] = 1'b1;
            end
            check({tag, " ready/done/eject"}, 32'({o_rdy, o_done, o_ej}),
                  32'({1'(cyc > e.dcyc), 1'(cyc == e.dcyc), ej_e}));
            if (!popped && (o_done || cyc == e.dcyc) && sb.size() > 0) begin
                got    = sb.pop_front();
                popped = 1'b1;
                check({tag, " short"},     32'(o_sh), 32'(got.sh));
                check({tag, " remaining"}, 32'(o_rm), 32'(got.rem));
                check({tag, " inv_q"},     32'(o_iq), 32'(got.iq));
                check({tag, " inv_d"},     32'(o_id), 32'(got.id));
                check({tag, " inv_n"},     32'(o_in), 32'(got.in_));
            end
            if (refill_at_sel) ref_v = (cyc == 1);
        end
        ref_v = 1'b0;
    endtask

    initial begin
        int exp_q;
        rst   = 1'b1;
        amt   = 8'd0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rv[2] = 1'b0;
        ref_v = 1'b0;
        ref_c = 2'b10;
        sel   = 0;
        minv[0] = '{20, 20, 20};
        minv[1] = '{2, 0, 0};
        minv[2] = '{0, 20, 20};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset ready/done/eject", 32'({o_rdy, o_done, o_ej}), 32'(5'b10000));
            check("reset short", 32'(o_sh), 32'd0);
            check("reset remaining", 32'(o_rm), 32'd0);
            check_invs("reset", s);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_req("req7", 0, 7, 1'b0);
        run_req("req0", 0, 0, 1'b0);
        run_req("noqd req5", 1, 5, 1'b0);
        run_req("non req3", 2, 3, 1'b0);

        // Reset in the middle of the first quarter pulse of a 10-unit request.
        sel = 0;
        @(negedge clk);
        amt   = 8'd10;
        rv[0] = 1'b1;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midpulse eject", 32'(o_ej), 32'(3'b100));
        #2 rst = 1'b1;
        #1;
        minv[0] = '{20, 20, 20};
        check("async reset ready/done/eject", 32'({o_rdy, o_done, o_ej}), 32'(5'b10000));
        check_invs("async reset", 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_req("post-reset req2", 0, 2, 1'b0);

        // Hold a quarter refill for 70 cycles; the count must stop at 63.
        sel   = 0;
        exp_q = minv[0][2];
        @(negedge clk);
        ref_c = 2'b10;
        ref_v = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            exp_q = (exp_q + 1 > 63) ? 63 : exp_q + 1;
            check("refill sat inv_q", 32'(o_iq), 32'(exp_q));
        end
        @(negedge clk);
        ref_v = 1'b0;
        minv[0][2] = exp_q;

        run_req("refill@select req5", 0, 5, 1'b1);
        run_req("req3 after refill", 0, 3, 1'b0);

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: observed %0d leftover entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-return back end for the vending machine: converts a change amount (in 5-cent units) into a timed sequence of coin-eject pulses on three coin-hopper solenoid lines. Coins are selected greedily (quarter, then dime, then nickel) against a per-denomination inventory. It is the mirror of the coin-acceptance front end: pulses in become value there, value in becomes pulses here. It sits between the vending FSM's change output and the `uo_out` solenoid pins of the `tt_um_` top.

## Interface

Parameters:
- PULSE_CYCLES, 4: cycles each eject line is held high per coin (≥1).
- GAP_CYCLES, 4: all-low cycles after each pulse (≥1).
- INV_W, 6: inventory counter width.
- INIT_Q / INIT_D / INIT_N, 20 / 20 / 20: reset inventory of quarters, dimes and nickels (≤ 2^INV_W−1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  change request.
- req_amount  in  8  change in 5-cent units; quarter=5, dime=2, nickel=1.
- req_ready  out  1  high only in IDLE.
- refill_valid  in  1  add one coin to inventory.
- refill_coin  in  2  00=nickel, 01=dime, 10=quarter, 11=ignored.
- eject_q / eject_d / eject_n  out  1 each  solenoid drive lines; at most one high.
- done  out  1  one-cycle pulse when a request finishes.
- short  out  1  valid with done; exact change not possible.
- remaining  out  8  undispensed units; valid with done, holds until the next accept.
- inv_q / inv_d / inv_n  out  INV_W each  current inventory.

## Operation

- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: req_ready=1. On req_valid the block loads rem=req_amount and goes to SELECT. A zero amount passes through SELECT to DONE with short=0.
- SELECT (1 cycle): first match wins.
  - rem≥5 and inv_q>0 → quarter.
  - rem≥2 and inv_d>0 → dime.
  - rem≥1 and inv_n>0 → nickel.
  - rem==0 → DONE, short=0.
  - otherwise → DONE, short=1.
  - On choosing a coin, rem and that inventory decrement in the same edge, then the block enters PULSE.
- Greedy selection does no backtracking. Example: rem=3 with no nickels gives a dime, then short=1 with remaining=1.
- PULSE: the selected eject line is high for exactly PULSE_CYCLES, then GAP.
- GAP: all eject lines low for GAP_CYCLES, then SELECT.
- DONE (1 cycle): done=1, short and remaining driven, then IDLE.
- Refill:
  - Accepted in any state, +1 to the selected inventory, saturating at 2^INV_W−1.
  - A refill and a SELECT decrement on the same counter in the same cycle leave it unchanged.
  - A refill during a request becomes visible to the next SELECT.
- req_valid outside IDLE is ignored; no queueing.
- Reset (async, any state): state=IDLE, req_ready=1, all eject lines 0, done=0, short=0, remaining=0, inventories=INIT_*. A coin mid-pulse is abandoned.

## Timing

- Accept edge = cycle 0. SELECT is at cycle 1 + k·(1+PULSE_CYCLES+GAP_CYCLES) for the k-th coin decision (k from 0). For a request dispensing n coins, done is at cycle 2 + n·(1+PULSE_CYCLES+GAP_CYCLES).
- Eject lines are registered. For the first coin they rise at cycle 2 and fall after PULSE_CYCLES cycles.
- req_ready falls at cycle 1 and returns the cycle after done.
- inv_* update on the SELECT edge, so they are visible during the first PULSE cycle.
- The narrowing of a 5/2/1 decrement from the 8-bit rem is exact; no wrap is possible because each decrement is guarded by its ≥ check.

## Test plan

- Defaults, request 7 (35c) → eject_q high cycles 2–5, eject_d high cycles 11–14, done at 20, short=0, remaining=0, inv_q=19, inv_d=19.
- Request 0 → done at cycle 2, no eject activity, short=0, inventories unchanged.
- Inventory with 0 quarters and 0 dimes (INIT_Q=0, INIT_D=0, INIT_N=2), request 5 → two nickel pulses, then done with short=1, remaining=3, inv_n=0.
- INIT_N=0, request 3 → one dime, then short=1, remaining=1.
- Refill quarter held 70 cycles from 20 with INV_W=6 → inv_q saturates at 63. A refill coincident with a quarter SELECT leaves the count unchanged.
- Assert rst mid-PULSE of a request 10 → eject lines low immediately, req_ready=1, inventories at INIT. Then request 2 → normal single dime, done at cycle 11.
